// File: rtl/stepper_pkg.sv
// Shared types and constants for the digit one-hot stepper: debounce state encoding,
// one-hot width and direction levels.
package stepper_pkg;

  localparam int ONEHOT_W = 8;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } db_state_e;

  function automatic logic [ONEHOT_W-1:0] digit_to_onehot(input logic [2:0] digit);
    return ONEHOT_W'(1) << digit;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce FSM for one raw asynchronous input.
// A level change is accepted after DEBOUNCE_CYCLES consecutive stable synced cycles.
//
//   state       | meaning
//   S_LOW       | debounced low, waiting for synced high
//   S_RISE_WAIT | synced high, counting stable cycles before accepting
//   S_HIGH      | debounced high, waiting for synced low
//   S_FALL_WAIT | synced low, counting stable cycles before accepting
module btn_debounce
  import stepper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise_strobe
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic            sync_q1;
  logic            sync_q2;
  db_state_e       state_q;
  db_state_e       state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            strobe_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOW;
      cnt_q       <= '0;
      rise_strobe <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rise_strobe <= strobe_d;
    end
  end

  // Wait counters load on entry and accept at terminal count zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync_q2) begin
          state_d = S_RISE_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_RISE_WAIT: begin
        if (!sync_q2) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = S_HIGH;
          strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HIGH: begin
        if (!sync_q2) begin
          state_d = S_FALL_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_FALL_WAIT: begin
        if (sync_q2) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign level = (state_q == S_HIGH) || (state_q == S_FALL_WAIT);

endmodule

// File: rtl/digit_onehot_stepper.sv
// Debounced step/direction inputs advance a wrapping digit index, emitted as a registered one-hot select.
// Optional auto-repeat while the step button is held: define STEPPER_AUTOREPEAT_EN.
module digit_onehot_stepper
  import stepper_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int TICK_DIV        = 1000000,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_CYCLES   = 250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                btn_step,
  input  logic                sw_dir,
  input  logic                run_mode,
  output logic [ONEHOT_W-1:0] onehot_out,
  output logic [2:0]          digit_out,
  output logic                step_pulse
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic          step_level;
  logic          step_rise;
  logic          dir_level;
  logic          dir_rise_unused;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic          press;
  logic          advance;
  logic [2:0]    digit_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw         (btn_step),
    .level       (step_level),
    .rise_strobe (step_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir_db (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw         (sw_dir),
    .level       (dir_level),
    .rise_strobe (dir_rise_unused)
  );

  // Prescaler freezes with ena low but is cleared whenever run mode is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (!run_mode) begin
      presc_q <= '0;
    end else if (ena) begin
      presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end
  end

  assign tick = ena && run_mode && (presc_q == PRESC_LAST);

`ifdef STEPPER_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam logic [RW-1:0] REP_LOAD = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt_q;
  logic          rep_strobe;

  // Reloads while released, so the first repeat lands REPEAT_CYCLES after the initial press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q  <= '0;
      rep_strobe <= 1'b0;
    end else begin
      rep_strobe <= 1'b0;
      if (!step_level) begin
        rep_cnt_q <= REP_LOAD;
      end else if (rep_cnt_q == '0) begin
        rep_cnt_q  <= REP_LOAD;
        rep_strobe <= 1'b1;
      end else begin
        rep_cnt_q <= rep_cnt_q - RW'(1);
      end
    end
  end

  assign press = step_rise | rep_strobe;
`else
  localparam int REPEAT_UNUSED = REPEAT_CYCLES;
  logic step_level_unused;

  assign step_level_unused = step_level;
  assign press             = step_rise;
`endif

  assign advance = ena && (press || tick);

  always_comb begin
    digit_next = digit_out;
    if (advance) begin
      if (dir_level == DIR_DOWN) begin
        digit_next = (digit_out == 3'd0) ? LAST_DIGIT : digit_out - 3'd1;
      end else begin
        digit_next = (digit_out == LAST_DIGIT) ? 3'd0 : digit_out + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_out  <= 3'd0;
      onehot_out <= digit_to_onehot(3'd0);
      step_pulse <= 1'b0;
    end else begin
      digit_out  <= digit_next;
      onehot_out <= digit_to_onehot(digit_next);
      step_pulse <= advance;
    end
  end

endmodule
